// File: rtl/reservation_station_pkg.sv
// Shared CPU definitions for the reservation station: default datapath widths
// and the common-data-bus broadcast packet.
package reservation_station_pkg;

    localparam int CPU_ROB_W  = 4;
    localparam int CPU_DATA_W = 32;
    localparam int CPU_OP_W   = 6;
    localparam int CPU_IMM_W  = 32;
    localparam int CPU_ADDR_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [CPU_ROB_W-1:0]  tag;
        logic [CPU_DATA_W-1:0] value;
    } cdb_pkt_t;

endpackage

// File: rtl/reservation_station_age_matrix.sv
// Older-than matrix: older_q[i][j] set means entry j was allocated before entry i.
// Grants the single requesting entry with no older requester.
module rs_age_matrix
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant
);

    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

    // A new entry is younger than every live entry; its column is cleared so
    // nothing counts it as older. Freed columns drop out the same way.
    always_comb begin
        older_d = older_q;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                older_d[i][j] = (alloc[i] ? valid[j] : older_q[i][j]) & ~free[j] & ~alloc[j];
            end
        end
        if (clr) begin
            older_d = '0;
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = req[i] & ~(|(older_q[i] & req));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched instructions until both operands are
// available (via dispatch, bypass or CDB wakeup) and issues them oldest-first.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ROB_W  = CPU_ROB_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter int OP_W   = CPU_OP_W,
    parameter int IMM_W  = CPU_IMM_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int N_CDB  = 3,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    clr,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic [OP_W-1:0]         dec_op,
    input  logic [IMM_W-1:0]        dec_imm,
    input  logic [ADDR_W-1:0]       dec_pc,
    input  logic [ROB_W-1:0]        dec_rd,
    input  logic                    dec_q1_busy,
    input  logic [ROB_W-1:0]        dec_q1,
    input  logic [DATA_W-1:0]       dec_v1,
    input  logic                    dec_q2_busy,
    input  logic [ROB_W-1:0]        dec_q2,
    input  logic [DATA_W-1:0]       dec_v2,
    input  logic [N_CDB-1:0]        cdb_valid,
    input  logic [N_CDB*ROB_W-1:0]  cdb_tag,
    input  logic [N_CDB*DATA_W-1:0] cdb_value,
    output logic                    alu_valid,
    input  logic                    alu_ready,
    output logic [OP_W-1:0]         alu_op,
    output logic [DATA_W-1:0]       alu_v1,
    output logic [DATA_W-1:0]       alu_v2,
    output logic [IMM_W-1:0]        alu_imm,
    output logic [ADDR_W-1:0]       alu_pc,
    output logic [ROB_W-1:0]        alu_rd,
    output logic                    rs_full,
    output logic [CNT_W-1:0]        rs_count
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  q1_busy_q, q1_busy_d, q2_busy_q, q2_busy_d;
    logic [OP_W-1:0]   op_q [DEPTH], op_d [DEPTH];
    logic [IMM_W-1:0]  imm_q [DEPTH], imm_d [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH], pc_d [DEPTH];
    logic [ROB_W-1:0]  rd_q [DEPTH], rd_d [DEPTH];
    logic [ROB_W-1:0]  q1_tag_q [DEPTH], q1_tag_d [DEPTH];
    logic [ROB_W-1:0]  q2_tag_q [DEPTH], q2_tag_d [DEPTH];
    logic [DATA_W-1:0] v1_q [DEPTH], v1_d [DEPTH];
    logic [DATA_W-1:0] v2_q [DEPTH], v2_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;

    cdb_pkt_t                    cdb [N_CDB];
    logic [DEPTH-1:0][N_CDB-1:0] hit1, hit2;
    logic [N_CDB-1:0]            dhit1, dhit2;
    logic [DEPTH-1:0]            free_oh, ready, grant, alloc_oh, free_vec;
    logic [IDX_W-1:0]            sel_idx;
    logic                        dispatch_fire, issue_fire;

    for (genvar p = 0; p < N_CDB; p++) begin : g_cdb
        assign cdb[p] = '{valid: cdb_valid[p],
                          tag:   cdb_tag[p*ROB_W +: ROB_W],
                          value: cdb_value[p*DATA_W +: DATA_W]};
        assign dhit1[p] = cdb[p].valid && (cdb[p].tag == dec_q1);
        assign dhit2[p] = cdb[p].valid && (cdb[p].tag == dec_q2);
        for (genvar e = 0; e < DEPTH; e++) begin : g_ent
            assign hit1[e][p] = cdb[p].valid && (cdb[p].tag == q1_tag_q[e]);
            assign hit2[e][p] = cdb[p].valid && (cdb[p].tag == q2_tag_q[e]);
        end
    end

    // Lowest-index free slot as a one-hot, from pre-edge occupancy only.
    for (genvar e = 0; e < DEPTH; e++) begin : g_free
        if (e == 0) begin : g_first
            assign free_oh[e] = ~valid_q[e];
        end else begin : g_rest
            assign free_oh[e] = ~valid_q[e] & (&valid_q[e-1:0]);
        end
    end

    // Several ports may carry the same tag; the lowest port index wins.
    function automatic logic [DATA_W-1:0] cdb_pick(input logic [N_CDB-1:0] hit);
        logic [DATA_W-1:0] val;
        val = '0;
        for (int p = N_CDB - 1; p >= 0; p--) begin
            if (hit[p]) val = cdb[p].value;
        end
        return val;
    endfunction

    assign rs_full       = (count_q == CNT_W'(DEPTH));
    assign dec_ready     = ~rs_full;
    assign rs_count      = count_q;
    assign ready         = valid_q & ~q1_busy_q & ~q2_busy_q;
    assign alu_valid     = rdy & ~clr & (|ready);
    assign issue_fire    = alu_valid & alu_ready;
    assign dispatch_fire = rdy & ~clr & dec_valid & ~rs_full;
    assign alloc_oh      = dispatch_fire ? free_oh : '0;
    assign free_vec      = issue_fire ? grant : '0;

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .valid (valid_q),
        .alloc (alloc_oh),
        .free  (free_vec),
        .req   (ready),
        .grant (grant)
    );

    always_comb begin
        sel_idx = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (grant[e]) sel_idx = IDX_W'(e);
        end
    end

    assign alu_op  = op_q[sel_idx];
    assign alu_v1  = v1_q[sel_idx];
    assign alu_v2  = v2_q[sel_idx];
    assign alu_imm = imm_q[sel_idx];
    assign alu_pc  = pc_q[sel_idx];
    assign alu_rd  = rd_q[sel_idx];

    always_comb begin
        valid_d   = valid_q;
        q1_busy_d = q1_busy_q;
        q2_busy_d = q2_busy_q;
        count_d   = count_q;
        op_d      = op_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        q1_tag_d  = q1_tag_q;
        q2_tag_d  = q2_tag_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        // Flush takes priority even while the pipeline is stalled.
        if (clr) begin
            valid_d = '0;
            count_d = '0;
        end else if (rdy) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (q1_busy_q[e] && (|hit1[e])) begin
                    q1_busy_d[e] = 1'b0;
                    v1_d[e]      = cdb_pick(hit1[e]);
                end
                if (q2_busy_q[e] && (|hit2[e])) begin
                    q2_busy_d[e] = 1'b0;
                    v2_d[e]      = cdb_pick(hit2[e]);
                end
            end
            valid_d = valid_d & ~free_vec;
            for (int e = 0; e < DEPTH; e++) begin
                if (alloc_oh[e]) begin
                    valid_d[e]   = 1'b1;
                    op_d[e]      = dec_op;
                    imm_d[e]     = dec_imm;
                    pc_d[e]      = dec_pc;
                    rd_d[e]      = dec_rd;
                    q1_tag_d[e]  = dec_q1;
                    q2_tag_d[e]  = dec_q2;
                    q1_busy_d[e] = dec_q1_busy & ~(|dhit1);
                    q2_busy_d[e] = dec_q2_busy & ~(|dhit2);
                    v1_d[e]      = (dec_q1_busy && (|dhit1)) ? cdb_pick(dhit1) : dec_v1;
                    v2_d[e]      = (dec_q2_busy && (|dhit2)) ? cdb_pick(dhit2) : dec_v2;
                end
            end
            case ({dispatch_fire, issue_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Payload is only meaningful while the entry is valid, so it is not reset.
    always_ff @(posedge clk) begin
        q1_busy_q <= q1_busy_d;
        q2_busy_q <= q2_busy_d;
        for (int e = 0; e < DEPTH; e++) begin
            op_q[e]     <= op_d[e];
            imm_q[e]    <= imm_d[e];
            pc_q[e]     <= pc_d[e];
            rd_q[e]     <= rd_d[e];
            q1_tag_q[e] <= q1_tag_d[e];
            q2_tag_q[e] <= q2_tag_d[e];
            v1_q[e]     <= v1_d[e];
            v2_q[e]     <= v2_d[e];
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: a per-cycle vector table for
// ordering/wakeup/bypass, plus sequences for fill, flush, stall and reset.
module tb_reservation_station;

    localparam int N_VEC = 23;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy, clr;
    logic        dec_valid, dec_ready;
    logic [5:0]  dec_op;
    logic [31:0] dec_imm, dec_pc;
    logic [3:0]  dec_rd;
    logic        dec_q1_busy, dec_q2_busy;
    logic [3:0]  dec_q1, dec_q2;
    logic [31:0] dec_v1, dec_v2;
    logic [2:0]  cdb_valid;
    logic [11:0] cdb_tag;
    logic [95:0] cdb_value;
    logic        alu_valid, alu_ready;
    logic [5:0]  alu_op;
    logic [31:0] alu_v1, alu_v2, alu_imm, alu_pc;
    logic [3:0]  alu_rd;
    logic        rs_full;
    logic [4:0]  rs_count;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
        .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_rd(dec_rd),
        .dec_q1_busy(dec_q1_busy), .dec_q1(dec_q1), .dec_v1(dec_v1),
        .dec_q2_busy(dec_q2_busy), .dec_q2(dec_q2), .dec_v2(dec_v2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_rd(alu_rd), .rs_full(rs_full), .rs_count(rs_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        dv;
        logic [3:0]  rd;
        logic        b1;
        logic [3:0]  t1;
        logic [31:0] v1;
        logic        b2;
        logic [3:0]  t2;
        logic [31:0] v2;
        logic [2:0]  cv;
        logic [3:0]  ct0, ct1, ct2;
        logic [31:0] cd0, cd1, cd2;
        logic        ar;
        logic [4:0]  e_cnt;
        logic        e_av;
        logic [3:0]  e_rd;
        logic [31:0] e_v1, e_v2;
    } vec_t;

    vec_t tab [N_VEC];

    function automatic vec_t mk(input int dv, rd, b1, t1, v1, b2, t2, v2,
                                input int cv, ct0, cd0, ct1, cd1, ct2, cd2,
                                input int ar, e_cnt, e_av, e_rd, e_v1, e_v2);
        vec_t x;
        x.dv = 1'(dv);   x.rd = 4'(rd);
        x.b1 = 1'(b1);   x.t1 = 4'(t1);   x.v1 = 32'(v1);
        x.b2 = 1'(b2);   x.t2 = 4'(t2);   x.v2 = 32'(v2);
        x.cv = 3'(cv);
        x.ct0 = 4'(ct0); x.cd0 = 32'(cd0);
        x.ct1 = 4'(ct1); x.cd1 = 32'(cd1);
        x.ct2 = 4'(ct2); x.cd2 = 32'(cd2);
        x.ar = 1'(ar);   x.e_cnt = 5'(e_cnt); x.e_av = 1'(e_av);
        x.e_rd = 4'(e_rd); x.e_v1 = 32'(e_v1); x.e_v2 = 32'(e_v2);
        return x;
    endfunction

    // Opcode, immediate and pc are derived from the destination tag so the
    // issued payload can be predicted from alu_rd's expected value.
    function automatic logic [5:0] op_of(input logic [3:0] rd);
        return {2'b10, rd};
    endfunction
    function automatic logic [31:0] imm_of(input logic [3:0] rd);
        return {20'h0, rd, 8'h5A};
    endfunction
    function automatic logic [31:0] pc_of(input logic [3:0] rd);
        return 32'h1000 + {26'h0, rd, 2'b00};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        dec_valid = 1'b0; dec_op = '0; dec_imm = '0; dec_pc = '0; dec_rd = '0;
        dec_q1_busy = 1'b0; dec_q1 = '0; dec_v1 = '0;
        dec_q2_busy = 1'b0; dec_q2 = '0; dec_v2 = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        alu_ready = 1'b0; clr = 1'b0; rdy = 1'b1;
    endtask

    task automatic drive_dec(input logic [3:0] rd, input logic b1, input logic [3:0] t1,
                             input logic [31:0] v1, input logic b2, input logic [3:0] t2,
                             input logic [31:0] v2);
        dec_valid = 1'b1; dec_rd = rd;
        dec_op = op_of(rd); dec_imm = imm_of(rd); dec_pc = pc_of(rd);
        dec_q1_busy = b1; dec_q1 = t1; dec_v1 = v1;
        dec_q2_busy = b2; dec_q2 = t2; dec_v2 = v2;
    endtask

    task automatic apply(input vec_t v);
        set_idle();
        if (v.dv) drive_dec(v.rd, v.b1, v.t1, v.v1, v.b2, v.t2, v.v2);
        cdb_valid = v.cv;
        cdb_tag   = {v.ct2, v.ct1, v.ct0};
        cdb_value = {v.cd2, v.cd1, v.cd0};
        alu_ready = v.ar;
    endtask

    initial begin
        //          dv rd b1 t1 v1      b2 t2 v2      cv  ct0 cd0       ct1 cd1    ct2 cd2     ar cnt av rd v1        v2
        tab[0]  = mk(1, 1, 1, 5, 0,      0, 0, 'h22,  0,  0, 0,        0, 0,      0, 0,       0, 0, 0, 0, 0,        0);
        tab[1]  = mk(1, 2, 0, 0, 'h10,   0, 0, 'h11,  0,  0, 0,        0, 0,      0, 0,       0, 1, 0, 0, 0,        0);
        tab[2]  = mk(1, 3, 0, 0, 'h30,   0, 0, 'h31,  0,  0, 0,        0, 0,      0, 0,       1, 2, 1, 2, 'h10,     'h11);
        tab[3]  = mk(0, 0, 0, 0, 0,      0, 0, 0,     0,  0, 0,        0, 0,      0, 0,       1, 2, 1, 3, 'h30,     'h31);
        tab[4]  = mk(0, 0, 0, 0, 0,      0, 0, 0,     1,  5, 'h1234,   0, 0,      0, 0,       1, 1, 0, 0, 0,        0);
        tab[5]  = mk(0, 0, 0, 0, 0,      0, 0, 0,     0,  0, 0,        0, 0,      0, 0,       1, 1, 1, 1, 'h1234,   'h22);
        tab[6]  = mk(0, 0, 0, 0, 0,      0, 0, 0,     0,  0, 0,        0, 0,      0, 0,       1, 0, 0, 0, 0,        0);
        tab[7]  = mk(1, 4, 1, 3, 0,      1, 3, 0,     0,  0, 0,        0, 0,      0, 0,       1, 0, 0, 0, 0,        0);
        tab[8]  = mk(0, 0, 0, 0, 0,      0, 0, 0,     3,  9, 'h99,     3, 'hAA,   0, 0,       1, 1, 0, 0, 0,        0);
        tab[9]  = mk(0, 0, 0, 0, 0,      0, 0, 0,     0,  0, 0,        0, 0,      0, 0,       1, 1, 1, 4, 'hAA,     'hAA);
        tab[10] = mk(1, 5, 1, 6, 0,      0, 0, 'h77,  0,  0, 0,        0, 0,      0, 0,       1, 0, 0, 0, 0,        0);
        tab[11] = mk(0, 0, 0, 0, 0,      0, 0, 0,     5,  6, 'h601,    0, 0,      6, 'h602,   1, 1, 0, 0, 0,        0);
        tab[12] = mk(0, 0, 0, 0, 0,      0, 0, 0,     0,  0, 0,        0, 0,      0, 0,       1, 1, 1, 5, 'h601,    'h77);
        tab[13] = mk(1, 6, 0, 0, 'h66,   1, 7, 0,     4,  0, 0,        0, 0,      7, 'h55,    1, 0, 0, 0, 0,        0);
        tab[14] = mk(0, 0, 0, 0, 0,      0, 0, 0,     0,  0, 0,        0, 0,      0, 0,       1, 1, 1, 6, 'h66,     'h55);
        tab[15] = mk(0, 0, 0, 0, 0,      0, 0, 0,     0,  0, 0,        0, 0,      0, 0,       1, 0, 0, 0, 0,        0);
        tab[16] = mk(1, 7, 1, 2, 0,      0, 0, 'h73,  0,  0, 0,        0, 0,      0, 0,       0, 0, 0, 0, 0,        0);
        tab[17] = mk(1, 8, 0, 0, 'h81,   0, 0, 'h82,  0,  0, 0,        0, 0,      0, 0,       0, 1, 0, 0, 0,        0);
        tab[18] = mk(0, 0, 0, 0, 0,      0, 0, 0,     0,  0, 0,        0, 0,      0, 0,       0, 2, 1, 8, 'h81,     'h82);
        tab[19] = mk(0, 0, 0, 0, 0,      0, 0, 0,     1,  2, 'h72,     0, 0,      0, 0,       0, 2, 1, 8, 'h81,     'h82);
        tab[20] = mk(0, 0, 0, 0, 0,      0, 0, 0,     0,  0, 0,        0, 0,      0, 0,       1, 2, 1, 7, 'h72,     'h73);
        tab[21] = mk(0, 0, 0, 0, 0,      0, 0, 0,     0,  0, 0,        0, 0,      0, 0,       1, 1, 1, 8, 'h81,     'h82);
        tab[22] = mk(0, 0, 0, 0, 0,      0, 0, 0,     0,  0, 0,        0, 0,      0, 0,       1, 0, 0, 0, 0,        0);

        set_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset count", rs_count, 5'd0);
        check("reset alu_valid", alu_valid, 1'b0);
        check("reset rs_full", rs_full, 1'b0);
        check("reset dec_ready", dec_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            @(negedge clk);
            apply(tab[i]);
            #1;
            check($sformatf("v%0d count", i), rs_count, tab[i].e_cnt);
            check($sformatf("v%0d alu_valid", i), alu_valid, tab[i].e_av);
            check($sformatf("v%0d dec_ready", i), dec_ready, 1'b1);
            if (tab[i].e_av) begin
                check($sformatf("v%0d alu_rd", i), alu_rd, tab[i].e_rd);
                check($sformatf("v%0d alu_v1", i), alu_v1, tab[i].e_v1);
                check($sformatf("v%0d alu_v2", i), alu_v2, tab[i].e_v2);
                check($sformatf("v%0d alu_op", i), alu_op, op_of(tab[i].e_rd));
                check($sformatf("v%0d alu_imm", i), alu_imm, imm_of(tab[i].e_rd));
                check($sformatf("v%0d alu_pc", i), alu_pc, pc_of(tab[i].e_rd));
            end
        end

        // Fill to capacity with ready entries while the ALU is stalled.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_idle();
            drive_dec(4'(i), 1'b0, 4'h0, 32'(i) + 32'h100, 1'b0, 4'h0, 32'(i) + 32'h200);
            exp_q.push_back(4'(i));
        end
        @(negedge clk);
        set_idle();
        drive_dec(4'd9, 1'b0, 4'h0, 32'h999, 1'b0, 4'h0, 32'h999);
        #1;
        check("fill count", rs_count, 5'd16);
        check("fill rs_full", rs_full, 1'b1);
        check("fill dec_ready", dec_ready, 1'b0);
        check("fill alu_valid", alu_valid, 1'b1);
        check("fill oldest rd", alu_rd, exp_q[0]);
        @(negedge clk);
        alu_ready = 1'b1;
        #1;
        check("17th rejected count", rs_count, 5'd16);
        check("full issue dec_ready", dec_ready, 1'b0);
        check("full issue rd", alu_rd, exp_q.pop_front());
        check("full issue v1", alu_v1, 32'h100);
        @(negedge clk);
        set_idle();
        #1;
        check("issue while full count", rs_count, 5'd15);
        check("issue while full rs_full", rs_full, 1'b0);
        check("next oldest rd", alu_rd, exp_q[0]);
        check("next oldest v2", alu_v2, 32'h201);

        // Flush with a dispatch offered in the same cycle.
        #1;
        clr = 1'b1;
        alu_ready = 1'b1;
        drive_dec(4'd3, 1'b0, 4'h0, 32'h1, 1'b0, 4'h0, 32'h2);
        #1;
        check("clr cycle alu_valid", alu_valid, 1'b0);
        @(negedge clk);
        set_idle();
        #1;
        check("after clr count", rs_count, 5'd0);
        check("after clr alu_valid", alu_valid, 1'b0);
        exp_q.delete();

        // Four entries all waiting on tag 9, then a stalled cycle carrying tag 9.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_idle();
            drive_dec(4'(10 + i), 1'b1, 4'd9, 32'h0, 1'b0, 4'h0, 32'h5);
        end
        @(negedge clk);
        set_idle();
        rdy = 1'b0;
        alu_ready = 1'b1;
        cdb_valid = 3'b001;
        cdb_tag = {4'h0, 4'h0, 4'd9};
        cdb_value = {32'h0, 32'h0, 32'h9};
        drive_dec(4'd1, 1'b0, 4'h0, 32'h1, 1'b0, 4'h0, 32'h1);
        #1;
        check("stall count", rs_count, 5'd4);
        check("stall alu_valid", alu_valid, 1'b0);
        @(negedge clk);
        set_idle();
        #1;
        check("after stall count", rs_count, 5'd4);
        check("after stall no wake", alu_valid, 1'b0);
        #1;
        clr = 1'b1;
        drive_dec(4'd2, 1'b0, 4'h0, 32'h1, 1'b0, 4'h0, 32'h1);
        @(negedge clk);
        set_idle();
        #1;
        check("flush 4 count", rs_count, 5'd0);
        check("flush 4 alu_valid", alu_valid, 1'b0);

        // Asynchronous reset between edges with five live entries.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_idle();
            drive_dec(4'(i), 1'b0, 4'h0, 32'h40, 1'b0, 4'h0, 32'h41);
        end
        @(negedge clk);
        set_idle();
        #1;
        check("pre reset count", rs_count, 5'd5);
        #1;
        rst = 1'b0;
        #1;
        check("async reset count", rs_count, 5'd0);
        check("async reset alu_valid", alu_valid, 1'b0);
        check("async reset rs_full", rs_full, 1'b0);
        check("async reset dec_ready", dec_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        drive_dec(4'd12, 1'b0, 4'h0, 32'hC1, 1'b0, 4'h0, 32'hC2);
        @(negedge clk);
        set_idle();
        #1;
        check("post reset count", rs_count, 5'd1);
        check("post reset alu_valid", alu_valid, 1'b1);
        check("post reset rd", alu_rd, 4'd12);
        check("post reset v1", alu_v1, 32'hC1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
